// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl
//   Front-end hazard and sequencing controller for the PC and the IF/ID
//   pipeline register. Each cycle it decides whether the PC advances and
//   whether IF/ID loads, holds or is squashed to a NOP. It also decides when
//   a bubble is injected into ID/EX. It handles taken-branch flush,
//   load-use stall, data-memory freeze and instruction-fetch wait, and keeps
//   saturating stall/flush event counters for performance debug.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2        source register fields of the instruction in ID
//   id_use_rs1/rs2       ID instruction actually reads that source
//   ex_memread, ex_rd    EX holds a load and its destination register
//   branch_taken         EX resolved a taken branch/jump this cycle
//   imem_ready           fetch data valid this cycle
//   dmem_busy            data memory stall, whole pipe freezes
//   pc_write             PC loads its next value
//   ifid_write           IF/ID loads (holds when 0)
//   ifid_flush           IF/ID loads a NOP, overrides ifid_write
//   idex_bubble          ID/EX loads control zeros
//   pipe_hold            freeze EX/MEM/WB registers
//   stall_cnt            cycles with pc_write=0, saturating
//   flush_cnt            taken-branch events, saturating
module if_id_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES    = 1,
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_REM = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] LU_REM    = 4'(LU_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             luh;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    always_comb begin
        luh = ex_memread && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // State register
    always_ff @(posedge clock) begin
        state_q     <= state_d;
        rem_q       <= rem_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    // Next-state logic. Priority: reset > branch > dmem freeze > state work.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (reset) begin
            state_d = RUN;
            rem_d   = '0;
        end else if (branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = FLUSH_REM;
            end else begin
                state_d = RUN;
            end
        end else if (dmem_busy) begin
            // freeze: state and remaining count both hold
            state_d = state_q;
        end else begin
            case (state_q)
                RUN: begin
                    if (luh && (LU_STALL_CYCLES > 1)) begin
                        state_d = LU_STALL;
                        rem_d   = LU_REM;
                    end
                end
                LU_STALL, FLUSH: begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (dmem_busy) begin
            pipe_hold  = 1'b1;
            // a freeze inside a flush window must keep squashing IF/ID
            ifid_flush = (state_q == FLUSH);
        end else begin
            case (state_q)
                RUN: begin
                    if (luh) begin
                        idex_bubble = 1'b1;
                    end else if (!imem_ready) begin
                        ifid_flush = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                LU_STALL: idex_bubble = 1'b1;
                FLUSH: begin
                    pc_write   = imem_ready;
                    ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Performance counters, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (branch_taken && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
